// File: rtl/bdemux_wb_16_pkg.sv
// -----------------------------------------------------------------------------
// bdemux_wb_16_pkg
// Shared definitions for the write-back demux and its commit queue:
//   - register-file geometry (NUM_REGS, SEL_W, BE_W)
//   - queue entry layout {sel, be, data}, with data in the low bits
//   - occupancy regions of the commit queue
//   - helpers for lane width, entry offsets and the 4-to-16 one-hot decode
// No ports (package).
// -----------------------------------------------------------------------------
package bdemux_wb_16_pkg;

  localparam int NUM_REGS  = 16;
  localparam int SEL_W     = 4;
  localparam int BE_W      = 2;
  localparam int DEF_WIDTH = 16;
  localparam int LANE_W    = DEF_WIDTH / 2;

  // Data always sits at bit 0 of an entry.
  localparam int ENT_DATA_OFS = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic int lane_width(input int width);
    return width / 2;
  endfunction

  function automatic int ent_be_ofs(input int width);
    return width;
  endfunction

  function automatic int ent_sel_ofs(input int width);
    return width + BE_W;
  endfunction

  function automatic int ent_width(input int width);
    return width + BE_W + SEL_W;
  endfunction

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_REGS'(1) << sel;
  endfunction

endpackage

// File: rtl/bdemux_wb_16_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// Synchronous FIFO holding pending write-back entries.
//   clk, rst_n     : clock, asynchronous active-low reset (empties the queue)
//   push_i         : enqueue din_i (ignored when full)
//   pop_i          : dequeue head (ignored when empty)
//   din_i, dout_o  : entry in / head entry out
//   count_o        : occupancy 0..DEPTH
//   occ_o          : occupancy region derived from count
//   ent_valid_o    : per-slot valid (slot holds a queued entry)
//   ent_sel_o      : per-slot sel field, slot i at [i*SEL_W +: SEL_W]
// -----------------------------------------------------------------------------
module wb_queue
  import bdemux_wb_16_pkg::*;
#(
  parameter int ENT_W   = 22,
  parameter int DEPTH   = 2,
  parameter int SEL_OFS = 18,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [ENT_W-1:0]       din_i,
  output logic [ENT_W-1:0]       dout_o,
  output logic [CNT_W-1:0]       count_o,
  output occ_e                   occ_o,
  output logic [DEPTH-1:0]       ent_valid_o,
  output logic [DEPTH*SEL_W-1:0] ent_sel_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  always_comb begin
    if (cnt_q == '0)            occ_o = OCC_EMPTY;
    else if (cnt_q == FULL_CNT) occ_o = OCC_FULL;
    else                        occ_o = OCC_PARTIAL;
  end

  // A full queue refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i && (occ_o != OCC_FULL);
  assign pop_ok  = pop_i  && (occ_o != OCC_EMPTY);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: slot validity comes from pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Slot i is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offs;
    assign offs                         = PTR_W'(i) - rd_ptr_q;
    assign ent_valid_o[i]               = ({1'b0, offs} < cnt_q);
    assign ent_sel_o[i*SEL_W +: SEL_W]  = mem_q[i][SEL_OFS +: SEL_W];
  end

endmodule

// File: rtl/bdemux_wb_16.sv
// -----------------------------------------------------------------------------
// bdemux_wb_16
// Write-back demux and 16-entry register bank. Write requests are queued in
// a small commit queue and retired one per cycle into the addressed register
// under byte enables, unless hold freezes the bank.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_valid     : write request present
//   wr_ready     : queue not full (depends on queue state only)
//   wr_sel       : destination register 0..15
//   wr_data      : write data
//   wr_be        : byte enables, bit0 = low lane, bit1 = high lane
//   hold         : freeze commits; pushes continue until full
//   regs_flat    : all registers, register k at [k*WIDTH +: WIDTH]
//   pend_mask    : bit k set while any queued entry targets register k
//   q_count      : queue occupancy
// -----------------------------------------------------------------------------
module bdemux_wb_16
  import bdemux_wb_16_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 2,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [BE_W-1:0]           wr_be,
  input  logic                      hold,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]       pend_mask,
  output logic [$clog2(DEPTH):0]    q_count
);

  localparam int LW      = lane_width(WIDTH);
  localparam int ENT_W   = ent_width(WIDTH);
  localparam int BE_OFS  = ent_be_ofs(WIDTH);
  localparam int SEL_OFS = ent_sel_ofs(WIDTH);

  logic [ENT_W-1:0]       push_ent, head_ent;
  logic [SEL_W-1:0]       head_sel;
  logic [BE_W-1:0]        head_be;
  logic [WIDTH-1:0]       head_data;
  logic                   push, commit;
  occ_e                   occ;
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH*SEL_W-1:0] ent_sel;
  logic [NUM_REGS-1:0]    wr_dec;
  logic [WIDTH-1:0]       regs_q [NUM_REGS];
  logic [WIDTH-1:0]       regs_d [NUM_REGS];

  // ---- accept stage: handshake into the commit queue ----
  assign wr_ready = (occ != OCC_FULL);
  assign push     = wr_valid && wr_ready;
  assign push_ent = {wr_sel, wr_be, wr_data};

  wb_queue #(
    .ENT_W   (ENT_W),
    .DEPTH   (DEPTH),
    .SEL_OFS (SEL_OFS)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (commit),
    .din_i       (push_ent),
    .dout_o      (head_ent),
    .count_o     (q_count),
    .occ_o       (occ),
    .ent_valid_o (ent_valid),
    .ent_sel_o   (ent_sel)
  );

  // ---- commit stage: pop head and merge into the bank ----
  assign commit    = (occ != OCC_EMPTY) && !hold;
  assign head_data = head_ent[ENT_DATA_OFS +: WIDTH];
  assign head_be   = head_ent[BE_OFS +: BE_W];
  assign head_sel  = head_ent[SEL_OFS +: SEL_W];

  // Register 0 is never a write target when it is hardwired to zero.
  always_comb begin
    wr_dec = commit ? sel_onehot(head_sel) : '0;
    if (R0_ZERO) wr_dec[0] = 1'b0;
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_dec[k]) begin
        if (head_be[0]) regs_d[k][LW-1:0]    = head_data[LW-1:0];
        if (head_be[1]) regs_d[k][WIDTH-1:LW] = head_data[WIDTH-1:LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*WIDTH +: WIDTH] = regs_q[k];
  end

  // ---- hazard view: registers targeted by any queued entry ----
  // Entries with no byte enables still mark their register.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend_mask = pend_mask | sel_onehot(ent_sel[i*SEL_W +: SEL_W]);
    end
    if (R0_ZERO) pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_bdemux_wb_16.sv
module tb_bdemux_wb_16;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic [1:0]  be;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic [3:0]   wr_sel = '0;
  logic [15:0]  wr_data = '0;
  logic [1:0]   wr_be = '0;
  logic         hold = 1'b0;

  logic         wr_ready, wr_ready_z;
  logic [255:0] regs_flat, regs_flat_z;
  logic [15:0]  pend_mask, pend_mask_z;
  logic [1:0]   q_count, q_count_z;

  int checks = 0;
  int failures = 0;

  bdemux_wb_16 #(.WIDTH(W), .DEPTH(DEPTH), .R0_ZERO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .hold(hold),
    .regs_flat(regs_flat), .pend_mask(pend_mask), .q_count(q_count)
  );

  bdemux_wb_16 #(.WIDTH(W), .DEPTH(DEPTH), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_z),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .hold(hold),
    .regs_flat(regs_flat_z), .pend_mask(pend_mask_z), .q_count(q_count_z)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] reg_of(input logic [255:0] f, input int k);
    return f[k*16 +: 16];
  endfunction

  // ---------------- scoreboard: reference queue and register bank ----------
  ent_t        mq[$];
  logic [15:0] mregs   [16];
  logic [15:0] mregs_z [16];
  ent_t        sb_e;
  logic        sb_pop, sb_push;
  logic [255:0] sb_flat, sb_flat_z;
  logic [15:0] sb_pend, sb_pend_z;

  initial begin
    for (int k = 0; k < 16; k++) begin
      mregs[k] = '0;
      mregs_z[k] = '0;
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    for (int k = 0; k < 16; k++) begin
      mregs[k] = '0;
      mregs_z[k] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      sb_pop  = (mq.size() != 0) && !hold;
      sb_push = wr_valid && (mq.size() != DEPTH);
      if (sb_pop) begin
        sb_e = mq.pop_front();
        if (sb_e.be[0]) mregs[sb_e.sel][7:0]  = sb_e.data[7:0];
        if (sb_e.be[1]) mregs[sb_e.sel][15:8] = sb_e.data[15:8];
        if (sb_e.sel != 4'd0) begin
          if (sb_e.be[0]) mregs_z[sb_e.sel][7:0]  = sb_e.data[7:0];
          if (sb_e.be[1]) mregs_z[sb_e.sel][15:8] = sb_e.data[15:8];
        end
      end
      if (sb_push) mq.push_back('{sel: wr_sel, data: wr_data, be: wr_be});
      #1;
      sb_pend = '0;
      foreach (mq[i]) sb_pend[mq[i].sel] = 1'b1;
      sb_pend_z = sb_pend;
      sb_pend_z[0] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        sb_flat[k*16 +: 16]   = mregs[k];
        sb_flat_z[k*16 +: 16] = mregs_z[k];
      end
      checks++;
      if (regs_flat !== sb_flat) begin
        failures++;
        $display("FAIL sb_regs t=%0t got=%h exp=%h", $time, regs_flat, sb_flat);
      end
      checks++;
      if (regs_flat_z !== sb_flat_z) begin
        failures++;
        $display("FAIL sb_regs_z t=%0t got=%h exp=%h", $time, regs_flat_z, sb_flat_z);
      end
      checks++;
      if ({q_count, pend_mask, wr_ready} !== {2'(mq.size()), sb_pend, mq.size() != DEPTH}) begin
        failures++;
        $display("FAIL sb_ctrl t=%0t got cnt=%0d pend=%h rdy=%b exp cnt=%0d pend=%h", $time,
                 q_count, pend_mask, wr_ready, mq.size(), sb_pend);
      end
      checks++;
      if (pend_mask_z !== sb_pend_z) begin
        failures++;
        $display("FAIL sb_pend_z t=%0t got=%h exp=%h", $time, pend_mask_z, sb_pend_z);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic [15:0] d, input logic [1:0] b);
    wr_valid = v;
    wr_sel   = s;
    wr_data  = d;
    wr_be    = b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({q_count, wr_ready, pend_mask} !== {2'd0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL reset_ctrl cnt=%0d rdy=%b pend=%h exp 0/1/0000", q_count, wr_ready, pend_mask);
    end
    checks++;
    if (regs_flat !== '0 || regs_flat_z !== '0) begin
      failures++;
      $display("FAIL reset_regs got=%h exp=0", regs_flat);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [255:0] exp;
    drive(1'b1, 4'd5, 16'hA5C3, 2'b11);
    tick();
    drive(1'b0, 4'd0, 16'h0, 2'b00);
    checks++;
    if (pend_mask !== 16'h0020 || q_count !== 2'd1) begin
      failures++;
      $display("FAIL basic_queued pend=%h cnt=%0d exp 0020/1", pend_mask, q_count);
    end
    tick();
    exp = '0;
    exp[5*16 +: 16] = 16'hA5C3;
    checks++;
    if (regs_flat !== exp) begin
      failures++;
      $display("FAIL basic_commit got=%h exp=%h", regs_flat, exp);
    end
    checks++;
    if (pend_mask !== 16'h0 || q_count !== 2'd0) begin
      failures++;
      $display("FAIL basic_drain pend=%h cnt=%0d exp 0000/0", pend_mask, q_count);
    end
  endtask

  task automatic test_hold_full();
    hold = 1'b1;
    drive(1'b1, 4'd3, 16'h1111, 2'b11);
    tick();
    drive(1'b1, 4'd3, 16'h2222, 2'b11);
    tick();
    checks++;
    if (wr_ready !== 1'b0 || q_count !== 2'd2 || pend_mask !== 16'h0008) begin
      failures++;
      $display("FAIL hold_full rdy=%b cnt=%0d pend=%h exp 0/2/0008", wr_ready, q_count, pend_mask);
    end
    checks++;
    if (reg_of(regs_flat, 3) !== 16'h0000) begin
      failures++;
      $display("FAIL hold_frozen reg3=%h exp=0000", reg_of(regs_flat, 3));
    end
    drive(1'b1, 4'd9, 16'hDEAD, 2'b11);
    tick();
    checks++;
    if (q_count !== 2'd2 || pend_mask !== 16'h0008) begin
      failures++;
      $display("FAIL hold_refuse cnt=%0d pend=%h exp 2/0008", q_count, pend_mask);
    end
    hold = 1'b0;
    tick();
    checks++;
    if (reg_of(regs_flat, 3) !== 16'h1111 || q_count !== 2'd1 || reg_of(regs_flat, 9) !== 16'h0) begin
      failures++;
      $display("FAIL release_first reg3=%h cnt=%0d reg9=%h exp 1111/1/0000",
               reg_of(regs_flat, 3), q_count, reg_of(regs_flat, 9));
    end
    drive(1'b0, 4'd0, 16'h0, 2'b00);
    tick();
    checks++;
    if (reg_of(regs_flat, 3) !== 16'h2222 || q_count !== 2'd0) begin
      failures++;
      $display("FAIL release_second reg3=%h cnt=%0d exp 2222/0", reg_of(regs_flat, 3), q_count);
    end
  endtask

  task automatic test_byte_lanes();
    logic [1:0]  bes  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [15:0] dats [4] = '{16'hFFFF, 16'h1234, 16'hABCD, 16'h5555};
    logic [15:0] exps [4] = '{16'hFFFF, 16'hFF34, 16'hAB34, 16'hAB34};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd7, dats[i], bes[i]);
      tick();
      drive(1'b0, 4'd0, 16'h0, 2'b00);
      checks++;
      if (pend_mask !== 16'h0080) begin
        failures++;
        $display("FAIL lane_pend%0d pend=%h exp=0080", i, pend_mask);
      end
      tick();
      checks++;
      if (reg_of(regs_flat, 7) !== exps[i] || q_count !== 2'd0) begin
        failures++;
        $display("FAIL lane%0d reg7=%h cnt=%0d exp %h/0", i, reg_of(regs_flat, 7), q_count, exps[i]);
      end
    end
  endtask

  task automatic test_r0_zero();
    drive(1'b1, 4'd0, 16'hBEEF, 2'b11);
    tick();
    drive(1'b0, 4'd0, 16'h0, 2'b00);
    checks++;
    if (pend_mask_z !== 16'h0000 || pend_mask !== 16'h0001) begin
      failures++;
      $display("FAIL r0_pend z=%h n=%h exp 0000/0001", pend_mask_z, pend_mask);
    end
    tick();
    checks++;
    if (reg_of(regs_flat_z, 0) !== 16'h0000 || reg_of(regs_flat, 0) !== 16'hBEEF) begin
      failures++;
      $display("FAIL r0_value z=%h n=%h exp 0000/BEEF", reg_of(regs_flat_z, 0), reg_of(regs_flat, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bb [16];
    for (int k = 0; k < 16; k++) begin
      bb[k] = 16'(k * 16'h1111) ^ 16'h5A5A;
      drive(1'b1, 4'(k), bb[k], 2'b11);
      tick();
      checks++;
      if (wr_ready !== 1'b1 || q_count !== 2'd1) begin
        failures++;
        $display("FAIL b2b_flow k=%0d rdy=%b cnt=%0d exp 1/1", k, wr_ready, q_count);
      end
    end
    drive(1'b0, 4'd0, 16'h0, 2'b00);
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (reg_of(regs_flat, k) !== bb[k]) begin
        failures++;
        $display("FAIL b2b_reg%0d got=%h exp=%h", k, reg_of(regs_flat, k), bb[k]);
      end
    end
    checks++;
    if (reg_of(regs_flat_z, 0) !== 16'h0 || reg_of(regs_flat_z, 15) !== bb[15] || q_count !== 2'd0) begin
      failures++;
      $display("FAIL b2b_z r0=%h r15=%h cnt=%0d exp 0000/%h/0",
               reg_of(regs_flat_z, 0), reg_of(regs_flat_z, 15), q_count, bb[15]);
    end
  endtask

  task automatic test_async_reset();
    hold = 1'b1;
    drive(1'b1, 4'd1, 16'h1357, 2'b11);
    tick();
    drive(1'b1, 4'd2, 16'h2468, 2'b11);
    tick();
    drive(1'b0, 4'd0, 16'h0, 2'b00);
    checks++;
    if (q_count !== 2'd2 || pend_mask !== 16'h0006) begin
      failures++;
      $display("FAIL arst_pre cnt=%0d pend=%h exp 2/0006", q_count, pend_mask);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q_count, wr_ready, pend_mask} !== {2'd0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL arst_ctrl cnt=%0d rdy=%b pend=%h exp 0/1/0000", q_count, wr_ready, pend_mask);
    end
    checks++;
    if (regs_flat !== '0 || regs_flat_z !== '0) begin
      failures++;
      $display("FAIL arst_regs got=%h exp=0", regs_flat);
    end
    #2;
    rst_n = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (regs_flat !== '0 || q_count !== 2'd0) begin
        failures++;
        $display("FAIL arst_stale%0d regs=%h cnt=%0d exp 0/0", i, regs_flat, q_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_full();
    test_byte_lanes();
    test_r0_zero();
    test_back_to_back();
    test_async_reset();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
